// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard controller.
//   FWD_RF / FWD_WB / FWD_MEM : E-stage operand select encodings
//   mc_state_t               : multi-cycle unit sequencer states
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } mc_state_t;

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: forwarding select for one E-stage source operand.
// Ports:
//   rs      in  REG_AW  source register of the instruction in E
//   rd_mem  in  REG_AW  destination register in M
//   rd_wb   in  REG_AW  destination register in W
//   we_mem  in  1       M writes the register file
//   we_wb   in  1       W writes the register file
//   sel     out 2       FWD_MEM / FWD_WB / FWD_RF
// M holds the younger result, so it takes priority over W on equal rd.
// Register x0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              we_mem,
  input  logic              we_wb,
  output logic [1:0]        sel
);

  logic hit_mem;
  logic hit_wb;

  assign hit_mem = we_mem && (rd_mem != '0) && (rd_mem == rs);
  assign hit_wb  = we_wb  && (rd_wb  != '0) && (rd_wb  == rs);

  always_comb begin
    sel = FWD_RF;
    if (hit_mem) begin
      sel = FWD_MEM;
    end else if (hit_wb) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage F/D/E/M/W core.
// Produces E-stage forwarding selects, load-use stalls, branch/JALR flushes,
// and sequences the multi-cycle E-stage unit (mul/div) with a timeout.
//
// Optional build macro: HAZARD_PERF_EN
//   defined   -> adds stallCnt / flushCnt saturating performance counters
//   undefined -> counters and their ports are absent
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   rs1D, rs2D            source registers of the instruction in D
//   rs1E, rs2E, rdE       sources / destination of the instruction in E
//   MemtoRegE             instruction in E is a load
//   PCSrcE                taken branch / JAL / JALR resolved in E
//   mcStartE              instruction in E needs the multi-cycle unit
//   mcDone                multi-cycle result valid (one-cycle pulse)
//   rdM, rdW              destination registers in M / W
//   RegWriteM, RegWriteW  M / W write the register file
//   ForwardAE, ForwardBE  operand selects for rs1E / rs2E
//   StallF, StallD, StallE  hold PC / D-reg / E-reg
//   FlushD, FlushE        bubble D-reg / E-reg on the next edge
//   mcBusy                sequencer is not IDLE
//   mcErr                 sticky timeout flag, cleared only by rst
//   stallCnt, flushCnt    (HAZARD_PERF_EN) cycles with StallF / any flush
//
// Sequencer states:
//   state | meaning
//   IDLE  | normal hazard handling, waiting for mcStartE
//   BUSY  | multi-cycle op in E; whole front end held, timeout running
//   DRAIN | result valid; E advances to M while F/D stay held
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic              MemtoRegE,
  input  logic              PCSrcE,
  input  logic              mcStartE,
  input  logic              mcDone,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              mcBusy,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  flushCnt,
`endif
  output logic              mcErr
);

  localparam int              TW      = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0]   TO_LAST = TW'(MC_TIMEOUT - 1);
  localparam logic [TW-1:0]   TO_ONE  = TW'(1);

  mc_state_t     state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [1:0] fwd_a, fwd_b;
  logic       load_use;
  logic       stall_f, stall_d, stall_e;
  logic       flush_d, flush_e;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs     (rs1E),
    .rd_mem (rdM),
    .rd_wb  (rdW),
    .we_mem (RegWriteM),
    .we_wb  (RegWriteW),
    .sel    (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs     (rs2E),
    .rd_mem (rdM),
    .rd_wb  (rdW),
    .we_mem (RegWriteM),
    .we_wb  (RegWriteW),
    .sel    (fwd_b)
  );

  assign load_use = MemtoRegE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    case (state_q)
      IDLE: begin
        // A redirect kills the D instruction anyway, so it overrides the stall.
        if (PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        if (mcStartE && !PCSrcE) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // The op in E must survive, so no flush here; the multi-cycle op
        // cannot redirect the PC and load-use waits until IDLE.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        cnt_d   = cnt_q + TO_ONE;
        if (mcDone) begin
          state_d = DRAIN;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DRAIN: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // While in reset the pipeline is flushed and nothing is stalled or forwarded.
  assign ForwardAE = rst ? FWD_RF : fwd_a;
  assign ForwardBE = rst ? FWD_RF : fwd_b;
  assign StallF    = rst ? 1'b0 : stall_f;
  assign StallD    = rst ? 1'b0 : stall_d;
  assign StallE    = rst ? 1'b0 : stall_e;
  assign FlushD    = rst ? 1'b1 : flush_d;
  assign FlushE    = rst ? 1'b1 : flush_e;
  assign mcBusy    = !rst && (state_q != IDLE);
  assign mcErr     = err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((FlushD || FlushE) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
`else
  logic unused_perf_cfg;
  assign unused_perf_cfg = (CNT_W > 0);
`endif

endmodule
